// File: rtl/multi_freq_counter.sv
// Multi-channel gated frequency counter: counts edges on each input over a common
// GATE_CYCLES window and publishes per-channel counts with a one-cycle valid strobe.
module multi_freq_counter #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned COUNT_W     = 16,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CHANNELS-1:0]         freq_in,
    input  logic                        en,
    input  logic                        edge_mode,
    output logic [CHANNELS*COUNT_W-1:0] freq_out,
    output logic [CHANNELS-1:0]         overflow,
    output logic                        valid,
    output logic                        busy
);

    // The timer doubles as the ARM-phase cycle counter, so it must hold both ranges.
    localparam int unsigned TIMER_MAX = (GATE_CYCLES > SYNC_STAGES + 1) ?
                                        GATE_CYCLES : SYNC_STAGES + 1;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX);

    typedef enum logic [1:0] {StIdle, StArm, StCount} state_e;

    state_e                                 state_q, state_d;
    logic [TIMER_W-1:0]                     timer_q, timer_d;
    logic                                   mode_q, mode_d;
    logic [SYNC_STAGES-1:0][CHANNELS-1:0]   sync_q;
    logic [CHANNELS-1:0]                    p_q;
    logic [CHANNELS-1:0][COUNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [CHANNELS-1:0]                    ovf_q, ovf_d, ovf_inc;
    logic [CHANNELS-1:0][COUNT_W-1:0]       freq_q, freq_d;
    logic [CHANNELS-1:0]                    oflow_q, oflow_d;
    logic                                   valid_q, valid_d;
    logic [CHANNELS-1:0]                    s;
    logic [CHANNELS-1:0]                    edges;

    assign s     = sync_q[SYNC_STAGES-1];
    assign edges = mode_q ? (s ^ p_q) : (s & ~p_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            p_q    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], freq_in};
            p_q    <= s;
        end
    end

    always_comb begin
        cnt_inc = cnt_q;
        ovf_inc = ovf_q;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (edges[c]) begin
                if (cnt_q[c] == '1) begin
                    ovf_inc[c] = 1'b1;
                end else begin
                    cnt_inc[c] = cnt_q[c] + COUNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        freq_d  = freq_q;
        oflow_d = oflow_q;
        valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                cnt_d   = '0;
                ovf_d   = '0;
                if (en) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                if (!en) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else if (timer_q == TIMER_W'(SYNC_STAGES)) begin
                    state_d = StCount;
                    timer_d = '0;
                    mode_d  = edge_mode;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            StCount: begin
                if (!en) begin
                    state_d = StIdle;
                    timer_d = '0;
                    cnt_d   = '0;
                    ovf_d   = '0;
                end else if (timer_q == TIMER_W'(GATE_CYCLES - 1)) begin
                    // Terminal cycle: its own edges still belong to the closing window.
                    freq_d  = cnt_inc;
                    oflow_d = ovf_inc;
                    valid_d = 1'b1;
                    timer_d = '0;
                    cnt_d   = '0;
                    ovf_d   = '0;
                    mode_d  = edge_mode;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                    cnt_d   = cnt_inc;
                    ovf_d   = ovf_inc;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            timer_q <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= '0;
            freq_q  <= '0;
            oflow_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            freq_q  <= freq_d;
            oflow_q <= oflow_d;
            valid_q <= valid_d;
        end
    end

    assign freq_out = freq_q;
    assign overflow = oflow_q;
    assign valid    = valid_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_multi_freq_counter.sv
// Randomised bench for multi_freq_counter: a pin-history model recomputes each window's
// counts from the sampled input levels and is compared against the DUT every cycle.
module tb_multi_freq_counter;

    localparam int G    = 100;
    localparam int W    = 4;
    localparam int CH   = 2;
    localparam int SS   = 2;
    localparam int MAXC = 20000;
    localparam int SAT  = (1 << W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              edge_mode = 1'b0;
    logic [CH-1:0]     freq_in = '0;
    logic [CH*W-1:0]   freq_out;
    logic [CH-1:0]     overflow;
    logic              valid;
    logic              busy;

    multi_freq_counter #(
        .GATE_CYCLES (G),
        .COUNT_W     (W),
        .CHANNELS    (CH),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .freq_in   (freq_in),
        .en        (en),
        .edge_mode (edge_mode),
        .freq_out  (freq_out),
        .overflow  (overflow),
        .valid     (valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: pin level and edge_mode seen at each rising clock edge.
    int            cyc = -1;
    logic [CH-1:0] pin [MAXC];
    logic          em  [MAXC];
    bit            m_active;
    int            m_k;
    int            exp_freq [CH];
    logic [CH-1:0] exp_ovf;
    logic          exp_valid;
    int            dut_last = -1;

    int            half [CH];
    int            ph   [CH];
    logic [CH-1:0] lvl = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        m_active  = 0;
        exp_valid = 1'b0;
        exp_ovf   = '0;
        for (int c = 0; c < CH; c++) exp_freq[c] = 0;
    endtask

    // A window published at edge p counts level changes between samples j-1 and j
    // for j in [p-G-1, p-2], under the edge_mode seen at edge p-G.
    task automatic publish(input int p);
        logic mode;
        int   n;
        logic a, b;
        mode = em[p-G];
        for (int c = 0; c < CH; c++) begin
            n = 0;
            for (int j = p - G - 1; j <= p - 2; j++) begin
                a = pin[j-1][c];
                b = pin[j][c];
                if (mode ? (a != b) : (!a && b)) n++;
            end
            exp_freq[c] = (n > SAT) ? SAT : n;
            exp_ovf[c]  = (n > SAT);
        end
        exp_valid = 1'b1;
    endtask

    task automatic model_edge();
        int d;
        cyc++;
        pin[cyc]  = rst_n ? freq_in : '0;
        em[cyc]   = edge_mode;
        exp_valid = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (!m_active) begin
            if (en) begin
                m_active = 1;
                m_k      = cyc;
            end
        end else if (!en) begin
            m_active = 0;
        end else begin
            d = cyc - m_k - (SS + 1);
            if (d >= G && d % G == 0) publish(cyc);
        end
    endtask

    task automatic sample();
        logic [CH*W-1:0] e;
        for (int c = 0; c < CH; c++) e[c*W +: W] = exp_freq[c][W-1:0];
        chk("valid", valid, exp_valid);
        chk("busy", busy, m_active);
        chk("freq_out", freq_out, e);
        chk("overflow", overflow, exp_ovf);
        if (valid === 1'b1) begin
            if (dut_last >= 0) chk("valid_gap", cyc - dut_last, G);
            dut_last = cyc;
        end
        if (!m_active) dut_last = -1;
    endtask

    task automatic step();
        for (int c = 0; c < CH; c++) begin
            if (half[c] != 0) begin
                ph[c]++;
                if (ph[c] >= half[c]) begin
                    ph[c]  = 0;
                    lvl[c] = ~lvl[c];
                end
            end
        end
        freq_in = lvl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        sample();
    endtask

    task automatic wait_valid(input int max);
        bit ok;
        ok = 0;
        for (int i = 0; i < max; i++) begin
            step();
            if (valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
        chk("valid_seen", ok, 1);
    endtask

    task automatic terminal_case(input int rise_at, input int first, input int second);
        en = 1'b0;
        half[0] = 0;
        half[1] = 0;
        lvl = '0;
        repeat (5) step();
        en = 1'b1;
        for (int i = 0; i <= rise_at; i++) begin
            if (i == rise_at) lvl[0] = 1'b1;
            step();
        end
        wait_valid(150);
        chk("term_first", freq_out[W-1:0], first);
        wait_valid(150);
        chk("term_second", freq_out[W-1:0], second);
    endtask

    initial begin
        int tbusy, tvalid, nval;
        model_reset();
        for (int c = 0; c < CH; c++) begin
            half[c] = 0;
            ph[c]   = 0;
        end

        // Reset held, then idle.
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();

        // Rising-edge counting.
        half[0] = 10;
        ph[0]   = $urandom_range(0, 9);
        half[1] = $urandom_range(3, 12);
        edge_mode = 1'b0;
        en = 1'b1;
        for (int w = 0; w < 3; w++) begin
            wait_valid(150);
            chk("rise_ch0", freq_out[W-1:0], 5);
            chk("rise_ovf0", overflow[0], 0);
        end

        // Mode switch mid-window applies from the next window.
        repeat (40) step();
        edge_mode = 1'b1;
        wait_valid(150);
        chk("mode_cur_ch0", freq_out[W-1:0], 5);
        wait_valid(150);
        chk("mode_next_ch0", freq_out[W-1:0], 10);

        // Saturation on ch1.
        edge_mode = 1'b0;
        half[1] = 2;
        wait_valid(150);
        chk("mode_after_ch0", freq_out[W-1:0], 10);
        wait_valid(150);
        chk("sat_ch1", freq_out[2*W-1:W], SAT);
        chk("sat_ovf1", overflow[1], 1);
        chk("sat_ch0", freq_out[W-1:0], 5);
        half[1] = 10;
        ph[1] = 0;
        wait_valid(150);
        wait_valid(150);
        chk("unsat_ch1", freq_out[2*W-1:W], 5);
        chk("unsat_ovf1", overflow[1], 0);

        // Level already high at enable is not an edge; then drop en mid-window.
        en = 1'b0;
        half[0] = 0;
        half[1] = 0;
        lvl = 2'b01;
        repeat (10) step();
        en = 1'b1;
        wait_valid(150);
        chk("en_hi_ch0", freq_out[W-1:0], 0);
        chk("en_hi_ovf", overflow, 0);
        half[0] = 10;
        wait_valid(150);
        repeat (50) step();
        en = 1'b0;
        step();
        chk("drop_busy", busy, 0);
        nval = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (valid === 1'b1) nval++;
        end
        chk("drop_no_valid", nval, 0);

        // Reset mid-window, then restart latency.
        en = 1'b1;
        wait_valid(150);
        repeat (70) step();
        rst_n = 1'b0;
        #1;
        chk("rst_freq", freq_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        tbusy  = -1;
        tvalid = -1;
        for (int t = 1; t <= 300 && tvalid < 0; t++) begin
            step();
            if (busy === 1'b1 && tbusy < 0) tbusy = t;
            if (valid === 1'b1) tvalid = t;
        end
        chk("rst_latency", tvalid - tbusy, SS + 1 + G);

        // Edge reaching the counter in the terminal cycle, and one cycle later.
        terminal_case(G + 1, 1, 0);
        terminal_case(G + 2, 0, 1);

        // Random traffic with mode flips and occasional enable drops.
        half[0] = $urandom_range(1, 8);
        half[1] = 0;
        edge_mode = 1'($urandom_range(0, 1));
        en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) edge_mode = ~edge_mode;
            if ($urandom_range(0, 299) == 0) en = ~en;
            if ($urandom_range(0, 3) == 0) lvl[1] = ~lvl[1];
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
